// File: rtl/ldpc_pkg.sv
// Shared types and default widths for the non-binary LDPC decode sequencer
// and the transform units it drives.
package ldpc_pkg;

  localparam int DEF_SYMBOL_BIT = 3;
  localparam int DEF_LLR_BIT    = 3;
  localparam int DEF_FIELD      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MSG,
    ST_CHK,
    ST_SYND,
    ST_RECOV,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_MSG  = 2'd1,
    OP_CHK  = 2'd2,
    OP_REC  = 2'd3
  } step_op_e;

endpackage

// File: rtl/ldpc_step_cnt.sv
// Step address counter: counts handshakes up to a run-time limit and wraps to
// zero on the last step; LIMIT bounds the largest limit it will ever see.
module ldpc_step_cnt #(
  parameter int LIMIT  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] limit_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // The LIMIT term keeps the counter from running past the largest pass.
  assign last_o = (addr_q == limit_i - ADDR_W'(1)) || (addr_q == ADDR_W'(LIMIT - 1));
  assign addr_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (advance_i) begin
      addr_d = last_o ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/ldpc_decode_sched.sv
// Decode sequencer: load, MSG/CHK iterations with syndrome check, recovery,
// driving the shared transform units one address per handshake.
module ldpc_decode_sched
  import ldpc_pkg::*;
#(
  parameter int N_VAR      = 8,
  parameter int N_EDGE     = 12,
  parameter int MAX_ITER   = 5,
  parameter int SYMBOL_BIT = ldpc_pkg::DEF_SYMBOL_BIT,
  parameter int ADDR_W     = 4,
  parameter int ITER_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  cim_mode_i,
  input  logic                  abort_i,
  input  logic                  in_vld_i,
  input  logic [SYMBOL_BIT-1:0] in_sym_i,
  output logic                  in_rdy_o,
  output logic                  step_vld_o,
  input  logic                  step_rdy_i,
  output logic [1:0]            step_op_o,
  output logic [ADDR_W-1:0]     step_addr_o,
  output logic [SYMBOL_BIT-1:0] sym_out_o,
  output logic                  cim_e_o,
  input  logic                  synd_ok_i,
  output logic [ITER_W-1:0]     iter_cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  success_o
);

  localparam int MAX_STEPS = (N_EDGE > N_VAR) ? N_EDGE : N_VAR;

  state_e            state_q;
  step_op_e          step_op_q;
  logic              step_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              success_q;
  logic              cim_e_q;
  logic [ITER_W-1:0] iter_q;

  logic              in_load;
  logic              fire;
  logic              abort_hit;
  logic              start_hit;
  logic              cnt_last;
  logic              step_last;
  logic [ADDR_W-1:0] cnt_limit;
  logic [ADDR_W-1:0] cnt_addr;

  // LOAD is a pass-through handshake between the channel and the datapath.
  assign in_load    = (state_q == ST_LOAD);
  assign step_vld_o = in_load ? in_vld_i : step_vld_q;
  assign in_rdy_o   = in_load & step_rdy_i;
  assign sym_out_o  = in_load ? in_sym_i : '0;

  assign fire      = step_vld_o & step_rdy_i;
  assign abort_hit = abort_i & (state_q != ST_IDLE);
  assign start_hit = start_i & (state_q == ST_IDLE);
  assign step_last = fire & cnt_last;
  assign cnt_limit = (state_q == ST_CHK) ? ADDR_W'(N_EDGE) : ADDR_W'(N_VAR);

  ldpc_step_cnt #(
    .LIMIT (MAX_STEPS),
    .ADDR_W(ADDR_W)
  ) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (abort_hit | start_hit),
    .advance_i(fire),
    .limit_i  (cnt_limit),
    .addr_o   (cnt_addr),
    .last_o   (cnt_last)
  );

  assign step_addr_o = cnt_addr;
  assign step_op_o   = step_op_q;
  assign cim_e_o     = cim_e_q;
  assign iter_cnt_o  = iter_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign success_o   = success_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_op_q  <= OP_LOAD;
      step_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      cim_e_q    <= 1'b0;
      iter_q     <= '0;
    end else if (abort_hit) begin
      state_q    <= ST_IDLE;
      step_op_q  <= OP_LOAD;
      step_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      iter_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cim_e_q    <= cim_mode_i;
            iter_q     <= '0;
            success_q  <= 1'b0;
            busy_q     <= 1'b1;
            step_op_q  <= OP_LOAD;
            step_vld_q <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (step_last) begin
            state_q    <= ST_MSG;
            step_op_q  <= OP_MSG;
            step_vld_q <= 1'b1;
          end
        end
        ST_MSG: begin
          if (step_last) begin
            state_q   <= ST_CHK;
            step_op_q <= OP_CHK;
          end
        end
        ST_CHK: begin
          if (step_last) begin
            state_q    <= ST_SYND;
            step_vld_q <= 1'b0;
          end
        end
        ST_SYND: begin
          step_vld_q <= 1'b1;
          if (synd_ok_i) begin
            success_q <= 1'b1;
            state_q   <= ST_RECOV;
            step_op_q <= OP_REC;
          end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
            success_q <= 1'b0;
            state_q   <= ST_RECOV;
            step_op_q <= OP_REC;
          end else begin
            iter_q    <= iter_q + ITER_W'(1);
            state_q   <= ST_MSG;
            step_op_q <= OP_MSG;
          end
        end
        ST_RECOV: begin
          if (step_last) begin
            state_q    <= ST_FIN;
            step_vld_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_decode_sched.sv
// Directed bench for the LDPC decode sequencer: nominal, max-iteration,
// backpressure/load gaps, abort and asynchronous reset scenarios.
module tb_ldpc_decode_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cim_mode = 1'b0;
  logic       abort = 1'b0;
  logic       in_vld = 1'b0;
  logic [2:0] in_sym = 3'd0;
  logic       step_rdy = 1'b0;
  logic       synd_ok = 1'b0;

  logic       in_rdy, step_vld, cim_e, busy, done, success;
  logic [1:0] step_op;
  logic [3:0] step_addr;
  logic [2:0] sym_out;
  logic [2:0] iter_cnt;

  ldpc_decode_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .cim_mode_i (cim_mode),
    .abort_i    (abort),
    .in_vld_i   (in_vld),
    .in_sym_i   (in_sym),
    .in_rdy_o   (in_rdy),
    .step_vld_o (step_vld),
    .step_rdy_i (step_rdy),
    .step_op_o  (step_op),
    .step_addr_o(step_addr),
    .sym_out_o  (sym_out),
    .cim_e_o    (cim_e),
    .synd_ok_i  (synd_ok),
    .iter_cnt_o (iter_cnt),
    .busy_o     (busy),
    .done_o     (done),
    .success_o  (success)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int log_q[$];
  int exp_q[$];
  logic [2:0] sym_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
  logic [3:0] pat = 4'b1001;

  int start_c, done_c, done_pulses, stalls, stall_bad, cim_bad, rdy_bad;
  bit got_done;
  logic [4:0] post_abort;
  logic [4:0] rst_ctl;
  logic [9:0] rst_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int op, input int addr, input int sym);
    return op * 256 + addr * 16 + sym;
  endfunction

  // k full iterations, optionally a partial one stopping before CHK addr part_chk
  task automatic build_exp(input int k, input int part_chk, input int n_rec);
    exp_q.delete();
    for (int a = 0; a < 8; a++) exp_q.push_back(enc(0, a, int'(sym_tab[a])));
    for (int it = 0; it < k; it++) begin
      for (int a = 0; a < 8; a++) exp_q.push_back(enc(1, a, 0));
      for (int a = 0; a < 12; a++) exp_q.push_back(enc(2, a, 0));
    end
    if (part_chk >= 0) begin
      for (int a = 0; a < 8; a++) exp_q.push_back(enc(1, a, 0));
      for (int a = 0; a < part_chk; a++) exp_q.push_back(enc(2, a, 0));
    end
    for (int a = 0; a < n_rec; a++) exp_q.push_back(enc(3, a, 0));
  endtask

  task automatic compare_seq(input string tag);
    int n;
    check($sformatf("%s.len", tag), log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic run(input int max_cyc, input bit bp, input bit gaps, input bit noisy,
                     input bit do_abort, input bit do_rst, input bit exp_cim);
    int  nloads = 0;
    int  bp_i = 0;
    int  a_cnt = -1;
    bit  prev_stall = 0;
    logic [5:0] prev_oa = '0;
    log_q.delete();
    got_done = 0; done_pulses = 0; stalls = 0; stall_bad = 0; cim_bad = 0; rdy_bad = 0;
    done_c = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cim_mode = exp_cim;
    @(negedge clk);
    start_c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      cim_mode = noisy ? c[0] : exp_cim;
      start = noisy && busy && (c % 7 == 3);
      if (bp && busy && step_op == 2'd2) begin
        step_rdy = pat[bp_i % 4];
        bp_i++;
      end else begin
        step_rdy = 1'b1;
      end
      in_vld = gaps ? (c % 3 != 2) : 1'b1;
      in_sym = sym_tab[nloads % 8];
      abort = 1'b0;
      if (do_abort && a_cnt < 0 && step_vld && step_op == 2'd2 && step_addr == 4'd5 && iter_cnt == 3'd2) begin
        abort = 1'b1;
        step_rdy = 1'b0;
        a_cnt = 0;
      end
      if (do_rst && busy && step_op == 2'd3 && step_addr == 4'd3) begin
        #2 rst_n = 1'b0;
        #1;
        rst_ctl = {busy, step_vld, done, success, cim_e};
        rst_cnt = {iter_cnt, step_op, step_addr, in_rdy};
        #3 rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      if (step_vld && step_rdy) begin
        log_q.push_back(enc(int'(step_op), int'(step_addr), int'(sym_out)));
        if (step_op == 2'd0) nloads++;
      end
      if (prev_stall && {step_op, step_addr} !== prev_oa) stall_bad++;
      prev_stall = step_vld && !step_rdy && step_op != 2'd0;
      prev_oa = {step_op, step_addr};
      if (prev_stall) stalls++;
      if (busy && cim_e !== exp_cim) cim_bad++;
      if (in_rdy !== ((busy && step_op == 2'd0) ? step_rdy : 1'b0)) rdy_bad++;
      if (done) begin
        done_pulses++;
        if (!got_done) done_c = cyc;
        got_done = 1;
      end
      if (a_cnt >= 0) begin
        if (a_cnt == 1) post_abort = {busy, step_vld, done, success, |iter_cnt};
        if (a_cnt == 4) break;
        a_cnt++;
      end
      if (got_done && cyc == done_c + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    // Reset values while RST_N is held low
    #12;
    check("rst0.ctl", {busy, step_vld, done, success, cim_e, in_rdy}, 0);
    check("rst0.cnt", {iter_cnt, step_op, step_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal decode, CIM on, syndrome met first time
    synd_ok = 1'b1;
    run(200, 0, 0, 0, 0, 0, 1'b1);
    check("nom.done", got_done, 1);
    check("nom.pulses", done_pulses, 1);
    check("nom.latency", done_c - start_c + 1, 1 + 8 + 21 + 8 + 1);
    check("nom.success", success, 1);
    check("nom.iter", iter_cnt, 0);
    check("nom.cim", cim_bad, 0);
    check("nom.cim_e", cim_e, 1);
    check("nom.in_rdy", rdy_bad, 0);
    check("nom.busy_after", busy, 0);
    build_exp(1, -1, 8);
    compare_seq("nom.seq");

    // Syndrome never met, CIM off, CIM_MODE and START toggled during the decode
    synd_ok = 1'b0;
    run(300, 0, 0, 1, 0, 0, 1'b0);
    check("max.done", got_done, 1);
    check("max.pulses", done_pulses, 1);
    check("max.latency", done_c - start_c + 1, 1 + 8 + 5 * 21 + 8 + 1);
    check("max.success", success, 0);
    check("max.iter", iter_cnt, 4);
    check("max.cim", cim_bad, 0);
    check("max.cim_e", cim_e, 0);
    build_exp(5, -1, 8);
    compare_seq("max.seq");

    // CHK backpressure 1,0,0,1 plus IN_VLD gaps during load
    synd_ok = 1'b1;
    run(400, 1, 1, 0, 0, 0, 1'b1);
    check("bp.done", got_done, 1);
    check("bp.stalled", stalls > 0, 1);
    check("bp.stable", stall_bad, 0);
    check("bp.in_rdy", rdy_bad, 0);
    check("bp.success", success, 1);
    build_exp(1, -1, 8);
    compare_seq("bp.seq");

    // Abort at CHK addr 5 in iteration 2
    synd_ok = 1'b0;
    post_abort = 5'h1f;
    run(300, 0, 0, 0, 1, 0, 1'b1);
    check("abort.no_done", done_pulses, 0);
    check("abort.after", post_abort, 0);
    check("abort.addr", step_addr, 0);
    build_exp(2, 5, 0);
    compare_seq("abort.seq");

    // Fresh decode after abort starts clean
    synd_ok = 1'b1;
    run(200, 0, 0, 0, 0, 0, 1'b0);
    check("reabort.done", got_done, 1);
    check("reabort.latency", done_c - start_c + 1, 39);
    check("reabort.iter", iter_cnt, 0);
    check("reabort.success", success, 1);
    check("reabort.cim_e", cim_e, 0);

    // Asynchronous reset mid-RECOV; START pulses while busy are ignored
    rst_ctl = 5'h1f;
    rst_cnt = 10'h3ff;
    run(200, 0, 0, 1, 0, 1, 1'b1);
    check("arst.ctl", rst_ctl, 0);
    check("arst.cnt", rst_cnt, 0);
    check("arst.cim", cim_bad, 0);
    check("arst.no_done", done_pulses, 0);
    build_exp(1, -1, 3);
    compare_seq("arst.seq");
    @(negedge clk);
    @(negedge clk);
    check("arst.idle", {busy, step_vld, success, cim_e}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
